// File: rtl/lshif_pkg.sv
// Shared definitions for the level-shifted bundled-data receiver.
package lshif_pkg;

   // Width of the settle-window counter; the largest bound it reaches is 14.
   localparam int CNT_W    = 4;

   // Fewest flops allowed in a toggle synchronizer chain.
   localparam int SYNC_MIN = 2;

   // Receiver FSM state encoding (2-bit, kept as plain constants).
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_CAPT   = 2'd2;
   localparam state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/lshif_sync_tog.sv
// Toggle synchronizer: STAGES-deep flop chain followed by a delay flop.
// ev pulses for one cycle whenever the synchronized level changes.
// Used for REQ_T on the receive side and for ACK_T on the send side.
module lshif_sync_tog
   import lshif_pkg::*;
#(
   parameter int STAGES = SYNC_MIN
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic ev
);

   logic [STAGES-1:0] sync_reg;
   logic              delay_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            // First stage samples the asynchronous toggle directly.
            always_ff @(posedge clk) begin
               if (srst) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= din;
            end
         end else begin : g_next
            // Later stages resolve metastability from the previous stage.
            always_ff @(posedge clk) begin
               if (srst) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   // Delayed copy of the synchronized level for edge detection.
   always_ff @(posedge clk) begin
      if (srst) delay_reg <= 1'b0;
      else      delay_reg <= sync_reg[STAGES-1];
   end

   assign ev = sync_reg[STAGES-1] ^ delay_reg;

endmodule

// File: rtl/lshif_rx_sync.sv
// Core-domain receiver for the bundled-data bus from the low-VDD island.
// Detects a synchronized REQ_T toggle, waits SETTLE cycles, captures DATA
// once, offers it on a VALID/READY handshake and toggles ACK_T on acceptance.
module lshif_rx_sync
   import lshif_pkg::*;
#(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         REQ_T,
   input  logic [W-1:0] DATA,
   output logic [W-1:0] Y,
   output logic         VALID,
   input  logic         READY,
   output logic         ACK_T,
   output logic         OVERRUN
);

   // Last counter value of the settle window (unused when SETTLE is 0).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

   logic             ev;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [W-1:0]     y_reg;
   logic             valid_reg;
   logic             ack_reg;
   logic             overrun_reg;

   lshif_sync_tog #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk  (CLK),
      .srst (RST),
      .din  (REQ_T),
      .ev   (ev)
   );

   // Transfer FSM: settle window, single DATA capture, handshake, ack toggle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         y_reg     <= '0;
         valid_reg <= 1'b0;
         ack_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (ev) begin
                  cnt_reg   <= '0;
                  state_reg <= (SETTLE == 0) ? ST_CAPT : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_LAST) state_reg <= ST_CAPT;
            end
            ST_CAPT: begin
               // DATA has been stable since before the request; sample it once here.
               y_reg     <= DATA;
               valid_reg <= 1'b1;
               state_reg <= ST_HOLD;
            end
            ST_HOLD: begin
               if (valid_reg && READY) begin
                  valid_reg <= 1'b0;
                  ack_reg   <= ~ack_reg;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Sticky flag: a new request arrived before the previous one was acknowledged.
   always_ff @(posedge CLK) begin
      if (RST)                             overrun_reg <= 1'b0;
      else if (ev && state_reg != ST_IDLE) overrun_reg <= 1'b1;
   end

   assign Y       = y_reg;
   assign VALID   = valid_reg;
   assign ACK_T   = ack_reg;
   assign OVERRUN = overrun_reg;

endmodule

// File: tb/tb_lshif_rx_sync.sv
// Self-checking bench for lshif_rx_sync: a default build (index 0) and a
// SYNC_STAGES=3 / SETTLE=0 build (index 1). Inputs change on falling edges,
// so REQ_T sampling is deterministic and latency is checked exactly.
module tb_lshif_rx_sync;

   localparam int A_SYNC = 2, A_SETTLE = 3;
   localparam int B_SYNC = 3, B_SETTLE = 0;

   logic       clk;
   logic       rst     [2];
   logic       req_t   [2];
   logic [7:0] data    [2];
   logic       ready   [2];
   logic [7:0] y       [2];
   logic       valid   [2];
   logic       ack_t   [2];
   logic       overrun [2];

   int errors = 0;
   int checks = 0;
   int acks   [2];
   int exp_lat[2];

   lshif_rx_sync #(.W(8), .SYNC_STAGES(A_SYNC), .SETTLE(A_SETTLE)) dut_a (
      .CLK(clk), .RST(rst[0]), .REQ_T(req_t[0]), .DATA(data[0]), .Y(y[0]),
      .VALID(valid[0]), .READY(ready[0]), .ACK_T(ack_t[0]), .OVERRUN(overrun[0])
   );

   lshif_rx_sync #(.W(8), .SYNC_STAGES(B_SYNC), .SETTLE(B_SETTLE)) dut_b (
      .CLK(clk), .RST(rst[1]), .REQ_T(req_t[1]), .DATA(data[1]), .Y(y[1]),
      .VALID(valid[1]), .READY(ready[1]), .ACK_T(ack_t[1]), .OVERRUN(overrun[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int sel, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d: got %0h want %0h", tag, sel, obs, exp);
      end
   endtask

   // One complete transfer; hold = cycles READY stays low once VALID is up (0: READY high throughout).
   task automatic xfer(input int sel, input logic [7:0] d, input int hold);
      int lat;
      bit seen;
      logic ack0;
      ack0       = ack_t[sel];
      data[sel]  = d;
      ready[sel] = (hold == 0);
      req_t[sel] = ~req_t[sel];
      lat  = 0;
      seen = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (valid[sel] === 1'b1) seen = 1;
      end
      chk("valid_seen", sel, 32'(seen), 32'd1);
      chk("latency", sel, lat, exp_lat[sel]);
      chk("y_capture", sel, 32'(y[sel]), 32'(d));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", sel, 32'(valid[sel]), 32'd1);
         chk("hold_y", sel, 32'(y[sel]), 32'(d));
         chk("hold_ack", sel, 32'(ack_t[sel]), 32'(ack0));
      end
      ready[sel] = 1'b1;
      @(negedge clk);
      acks[sel]++;
      chk("accept_valid", sel, 32'(valid[sel]), 32'd0);
      chk("ack_toggle", sel, 32'(ack_t[sel]), 32'(acks[sel] % 2));
      ready[sel] = 1'b0;
      $display("xfer dut%0d data=%02h hold=%0d latency=%0d acks=%0d", sel, d, hold, lat, acks[sel]);
   endtask

   initial begin
      int vcount;
      bit seen;
      int lat;
      exp_lat[0] = A_SYNC + 1 + A_SETTLE + 1;
      exp_lat[1] = B_SYNC + 1 + B_SETTLE + 1;
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; req_t[s] = 1'b1; data[s] = 8'hFF; ready[s] = 1'b0; acks[s] = 0;
      end

      // 1: reset with REQ_T high and DATA all ones
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_y", s, 32'(y[s]), 32'd0);
         chk("rst_valid", s, 32'(valid[s]), 32'd0);
         chk("rst_ack", s, 32'(ack_t[s]), 32'd0);
         chk("rst_overrun", s, 32'(overrun[s]), 32'd0);
      end
      $display("reset: outputs checked");
      for (int s = 0; s < 2; s++) req_t[s] = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) rst[s] = 1'b0;
      repeat (3) @(negedge clk);

      // 2: single transfer, READY already high
      xfer(0, 8'hA5, 0);
      // 3: backpressure for 10 cycles
      xfer(0, 8'h3C, 10);
      chk("no_overrun_basic", 0, 32'(overrun[0]), 32'd0);

      // random data and backpressure
      repeat (6) begin
         xfer(0, 8'($urandom), int'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      chk("no_overrun_random", 0, 32'(overrun[0]), 32'd0);

      // 4: second toggle 4 cycles after the first, before ACK_T
      data[0]  = 8'h5A;
      ready[0] = 1'b1;
      req_t[0] = ~req_t[0];
      repeat (4) @(negedge clk);
      req_t[0] = ~req_t[0];
      lat  = 4;
      seen = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (valid[0] === 1'b1) seen = 1;
      end
      chk("ovr_valid_seen", 0, 32'(seen), 32'd1);
      chk("ovr_latency", 0, lat, exp_lat[0]);
      chk("ovr_y", 0, 32'(y[0]), 32'h5A);
      @(negedge clk);
      acks[0]++;
      chk("ovr_ack", 0, 32'(ack_t[0]), 32'(acks[0] % 2));
      chk("ovr_flag", 0, 32'(overrun[0]), 32'd1);
      vcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid[0] === 1'b1) vcount++;
      end
      ready[0] = 1'b0;
      chk("ovr_single_word", 0, vcount, 0);
      chk("ovr_ack_once", 0, 32'(ack_t[0]), 32'(acks[0] % 2));
      chk("ovr_sticky", 0, 32'(overrun[0]), 32'd1);
      $display("overrun: words_after=%0d overrun=%0b", vcount, overrun[0]);

      // 5: reset while the settle window is running
      data[0]  = 8'h77;
      ready[0] = 1'b1;
      req_t[0] = ~req_t[0];
      repeat (4) @(negedge clk);
      rst[0]   = 1'b1;
      req_t[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst[0]  = 1'b0;
      acks[0] = 0;
      chk("midrst_overrun", 0, 32'(overrun[0]), 32'd0);
      chk("midrst_ack", 0, 32'(ack_t[0]), 32'd0);
      vcount = 0;
      repeat (15) begin
         @(negedge clk);
         if (valid[0] === 1'b1) vcount++;
      end
      chk("midrst_no_valid", 0, vcount, 0);
      chk("midrst_ack_still", 0, 32'(ack_t[0]), 32'd0);
      ready[0] = 1'b0;
      $display("mid-transfer reset: valid_count=%0d", vcount);
      xfer(0, 8'hC3, 0);
      chk("midrst_after_overrun", 0, 32'(overrun[0]), 32'd0);

      // 6: SYNC_STAGES=3, SETTLE=0 build, four back-to-back transfers
      for (int i = 1; i <= 4; i++) xfer(1, 8'(i), 0);
      chk("b_ack_count", 1, acks[1], 4);
      chk("b_overrun", 1, 32'(overrun[1]), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
